// File: rtl/keypad_decoder.sv
// Keypad event decoder: synchronises the scanner code, decodes it to a key index,
// debounces press/release and queues events in a show-ahead valid/ready FIFO.
module keypad_decoder #(
  parameter int DEB_CYCLES = 1080000,
  parameter int CNT_W      = 21,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       ev_ready,
  input  logic       clr,
  output logic       ev_valid,
  output logic [3:0] ev_code,
  output logic       ev_release,
  output logic       key_down,
  output logic [3:0] key_code,
  output logic       overflow,
  output logic       code_err,
  output logic [1:0] dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [PW:0]      DEPTH_V  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  // Handshake: an event transfers on any clk edge where ev_valid && ev_ready;
  // ev_code/ev_release are stable while ev_valid=1 and the head is not popped.

  logic [7:0]       sync1_q, sync2_q;
  logic             samp_vld_q, samp_vld_d;
  logic [3:0]       samp_idx_q, samp_idx_d;
  logic             illegal;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_down_q, key_down_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [4:0]       mem_q [FIFO_DEPTH];
  logic             overflow_q, overflow_d;
  logic             code_err_q, code_err_d;
  logic             push, push_rel, do_push, pop, full, empty, match, last;
  logic [PW:0]      count;
  logic [4:0]       head;

  always_comb begin
    samp_vld_d = 1'b1;
    samp_idx_d = 4'd0;
    illegal    = 1'b0;
    case (sync2_q)
      8'h01: samp_idx_d = 4'd1;
      8'h02: samp_idx_d = 4'd2;
      8'h04: samp_idx_d = 4'd3;
      8'h08: samp_idx_d = 4'd4;
      8'h10: samp_idx_d = 4'd5;
      8'h20: samp_idx_d = 4'd6;
      8'h40: samp_idx_d = 4'd7;
      8'h80: samp_idx_d = 4'd8;
      8'h90: samp_idx_d = 4'd9;
      8'hA0: samp_idx_d = 4'd0;
      8'hB0: samp_idx_d = 4'd10;
      8'hC0: samp_idx_d = 4'd11;
      8'h00: samp_vld_d = 1'b0;
      default: begin
        samp_vld_d = 1'b0;
        illegal    = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_rel = 1'b0;
    match    = samp_vld_q && (samp_idx_q == cand_q);
    last     = (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: if (samp_vld_q) begin
        state_d = PRESS_CHK;
        cand_d  = samp_idx_q;
        cnt_d   = CNT_W'(1);
      end
      PRESS_CHK: if (match) begin
        if (last) begin
          push    = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      HELD: if (!match) begin
        state_d = REL_CHK;
        cnt_d   = CNT_W'(1);
      end
      REL_CHK: if (match) begin
        // Key seen again before release qualified: treat as contact bounce.
        state_d = HELD;
        cnt_d   = '0;
      end else if (last) begin
        push     = 1'b1;
        push_rel = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    key_down_d = (state_d == HELD) || (state_d == REL_CHK);
    key_code_d = key_down_d ? cand_d : 4'd0;
  end

  always_comb begin
    count      = wr_q - rd_q;
    empty      = (wr_q == rd_q);
    full       = (count == DEPTH_V);
    pop        = !empty && ev_ready;
    do_push    = push && (!full || pop);
    wr_d       = wr_q + (PW+1)'(do_push);
    rd_d       = rd_q + (PW+1)'(pop);
    overflow_d = (push && full && !pop) ? 1'b1 : (clr ? 1'b0 : overflow_q);
    code_err_d = illegal ? 1'b1 : (clr ? 1'b0 : code_err_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_vld_q <= 1'b0;
      samp_idx_q <= '0;
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      key_down_q <= 1'b0;
      key_code_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
      code_err_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q    <= data;
      sync2_q    <= sync1_q;
      samp_vld_q <= samp_vld_d;
      samp_idx_q <= samp_idx_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      key_down_q <= key_down_d;
      key_code_q <= key_code_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      overflow_q <= overflow_d;
      code_err_q <= code_err_d;
      if (do_push) mem_q[wr_q[PW-1:0]] <= {cand_q, push_rel};
    end
  end

  assign head       = mem_q[rd_q[PW-1:0]];
  assign ev_valid   = !empty;
  assign ev_code    = ev_valid ? head[4:1] : 4'd0;
  assign ev_release = ev_valid & head[0];
  assign key_down   = key_down_q;
  assign key_code   = key_code_q;
  assign overflow   = overflow_q;
  assign code_err   = code_err_q;
  assign dbg_state  = state_q;

endmodule
